// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an 8-input serial ADC: walks a channel mask, runs one
// conversion per selected channel and keeps the latest result per channel.
module adc_scan_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 10,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont_mode,
  input  logic                      stop,
  input  logic [NUM_CH-1:0]         chan_mask,
  output logic                      adc_en,
  output logic [$clog2(NUM_CH)-1:0] adc_ch,
  input  logic                      adc_done,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic [$clog2(NUM_CH)-1:0] rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_CH-1:0]         res_valid,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      timeout_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_STORE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-1:0] mask_q;
  logic              stop_pend;
  logic              done_q;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] data_q;
  logic              capt_ok;
  logic              empty_done;
  logic [DATA_W-1:0] result [NUM_CH];

  logic [NUM_CH-1:0] upper_mask;
  logic              has_next;
  logic [CH_W-1:0]   next_ch;

  function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  // Channels of the latched mask strictly above the current one.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upper_mask[i] = mask_q[i] && (i > int'(ch));
    end
  end

  assign has_next    = |upper_mask;
  assign next_ch     = lowest_bit(upper_mask);

  assign adc_en      = (state == S_CONVERT);
  assign adc_ch      = ch;
  assign busy        = (state != S_IDLE);
  assign scan_done   = (state == S_DONE) || empty_done;
  assign rd_data     = result[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      mask_q      <= '0;
      stop_pend   <= 1'b0;
      done_q      <= 1'b0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      data_q      <= '0;
      capt_ok     <= 1'b0;
      empty_done  <= 1'b0;
      res_valid   <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      done_q     <= adc_done;
      empty_done <= 1'b0;
      if (state != S_IDLE && stop) stop_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (start) begin
            if (chan_mask != '0) begin
              mask_q      <= chan_mask;
              ch          <= lowest_bit(chan_mask);
              res_valid   <= '0;
              timeout_err <= 1'b0;
              settle_cnt  <= '0;
              state       <= S_SELECT;
            end else begin
              empty_done <= 1'b1;
            end
          end
        end

        // Settling only counts while the ADC has dropped done from the last channel.
        S_SELECT: begin
          if (adc_done) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
            to_cnt <= '0;
            state  <= S_CONVERT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_CONVERT: begin
          if (!done_q && adc_done) begin
            data_q  <= adc_data;
            capt_ok <= 1'b1;
            state   <= S_STORE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            capt_ok     <= 1'b0;
            state       <= S_STORE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_STORE: begin
          if (capt_ok) begin
            result[ch]    <= data_q;
            res_valid[ch] <= 1'b1;
          end
          if (has_next && !stop_pend) begin
            ch         <= next_ch;
            settle_cnt <= '0;
            state      <= S_SELECT;
          end else begin
            state <= S_DONE;
          end
        end

        // Continuous mode picks up the live mask so software can retarget between passes.
        S_DONE: begin
          if (cont_mode && !stop_pend && chan_mask != '0) begin
            mask_q     <= chan_mask;
            ch         <= lowest_bit(chan_mask);
            settle_cnt <= '0;
            state      <= S_SELECT;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
